// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of the single-ported 64x32 data memory.
// Supports capped locked bursts and returns registered read data with a one-cycle valid.
module dm_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic [5:0]  addr0,
  input  logic [5:0]  addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [5:0]  dm_addr,
  output logic        dm_wr,
  output logic        dm_rd,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  state_t      fsm_q, fsm_d;
  logic        last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic        hold0, hold1, arb_last, g0, g1;
  logic [3:0]  cnt_inc;

  always_comb begin
    hold0    = (fsm_q == LOCK0) && req0 && (cnt_q < MAX_B);
    hold1    = (fsm_q == LOCK1) && req1 && (cnt_q < MAX_B);
    // A lock that lapses hands contention to the other port.
    arb_last = (fsm_q == LOCK0) ? 1'b0 : (fsm_q == LOCK1) ? 1'b1 : last_q;
    cnt_inc  = (hold0 || hold1) ? cnt_q + 4'd1 : 4'd1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst_n) begin
      if (hold0) begin
        g0 = 1'b1;
      end else if (hold1) begin
        g1 = 1'b1;
      end else if (req0 && req1) begin
        g0 = arb_last;
        g1 = ~arb_last;
      end else begin
        g0 = req0;
        g1 = req1;
      end
    end
  end

  always_comb begin
    fsm_d     = ARB;
    cnt_d     = 4'd0;
    last_d    = last_q;
    rvalid0_d = g0 && !we0;
    rvalid1_d = g1 && !we1;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    if (g0) begin
      last_d = 1'b0;
      cnt_d  = cnt_inc;
      if (lock0 && (cnt_inc < MAX_B)) fsm_d = LOCK0;
      if (!we0) rdata0_d = dm_rdata;
    end else if (g1) begin
      last_d = 1'b1;
      cnt_d  = cnt_inc;
      if (lock1 && (cnt_inc < MAX_B)) fsm_d = LOCK1;
      if (!we1) rdata1_d = dm_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= ARB;
      last_q    <= 1'b1;
      cnt_q     <= 4'd0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= 32'd0;
      rdata1_q  <= 32'd0;
    end else begin
      fsm_q     <= fsm_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // dm_rd on writes makes the memory forward wdata instead of the stored word.
  assign gnt0     = g0;
  assign gnt1     = g1;
  assign dm_wr    = (g0 && we0) || (g1 && we1);
  assign dm_rd    = dm_wr;
  assign dm_addr  = g1 ? addr1 : addr0;
  assign dm_wdata = g1 ? wdata1 : wdata0;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic checked against a transaction-level model of owner/beats/last.
module tb_dm_arbiter;

  localparam int MAXB = 4;

  typedef struct {
    bit          req0, req1, we0, we1, lock0, lock1;
    logic [5:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
  } stim_t;

  typedef struct {
    stim_t s;
    bit    exp_g0;
    bit    exp_g1;
  } vec_t;

  logic        clk, rst_n;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [5:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [5:0]  dm_addr;
  logic        dm_wr, dm_rd;
  logic [31:0] dm_wdata, dm_rdata;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];

  int          checks = 0;
  int          errors = 0;

  int          m_owner, m_beats, m_last;
  bit          exp_rv0, exp_rv1;
  logic [31:0] exp_rd0, exp_rd1;

  vec_t        tbl[$];

  dm_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .dm_addr(dm_addr), .dm_wr(dm_wr), .dm_rd(dm_rd),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory: dm_rd forwards write data, otherwise the stored word.
  assign dm_rdata = dm_rd ? dm_wdata : mem[dm_addr];
  always @(posedge clk) if (dm_wr) mem[dm_addr] <= dm_wdata;

  function automatic stim_t mk(bit r0, bit r1, bit w0, bit w1, bit l0, bit l1,
                               logic [5:0] a0, logic [5:0] a1,
                               logic [31:0] d0, logic [31:0] d1);
    stim_t s;
    s.req0 = r0; s.req1 = r1; s.we0 = w0; s.we1 = w1; s.lock0 = l0; s.lock1 = l1;
    s.addr0 = a0; s.addr1 = a1; s.wdata0 = d0; s.wdata1 = d1;
    return s;
  endfunction

  task automatic addVec(input stim_t s, input bit eg0, input bit eg1);
    vec_t v;
    v.s = s; v.exp_g0 = eg0; v.exp_g1 = eg1;
    tbl.push_back(v);
  endtask

  task automatic applyStimulus(input stim_t s);
    req0 = s.req0; req1 = s.req1; we0 = s.we0; we1 = s.we1;
    lock0 = s.lock0; lock1 = s.lock1; addr0 = s.addr0; addr1 = s.addr1;
    wdata0 = s.wdata0; wdata1 = s.wdata1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_owner = -1; m_last = 1; m_beats = 0;
    exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_rd0 = 32'd0; exp_rd1 = 32'd0;
  endtask

  // One bus cycle: drive, predict the winner from owner/beats/last, compare, advance.
  task automatic runCycle(input stim_t s, input bit tbl_chk, input bit eg0, input bit eg1);
    int          w, nb;
    bit          rq[2], lk[2], wr[2];
    logic [5:0]  ad[2];
    logic [31:0] wd[2];
    applyStimulus(s);
    #2;
    rq[0] = s.req0;  rq[1] = s.req1;  lk[0] = s.lock0; lk[1] = s.lock1;
    wr[0] = s.we0;   wr[1] = s.we1;   ad[0] = s.addr0; ad[1] = s.addr1;
    wd[0] = s.wdata0; wd[1] = s.wdata1;
    w = -1;
    nb = 0;
    if (m_owner >= 0 && rq[m_owner] && m_beats < MAXB) begin
      w = m_owner;
      nb = m_beats + 1;
    end else begin
      if (rq[0] && rq[1]) w = (m_last == 0) ? 1 : 0;
      else if (rq[0]) w = 0;
      else if (rq[1]) w = 1;
      nb = 1;
    end
    checkOutput("gnt0", gnt0, 32'(w == 0));
    checkOutput("gnt1", gnt1, 32'(w == 1));
    checkOutput("dm_wr", dm_wr, 32'(w >= 0 && wr[w]));
    checkOutput("dm_rd", dm_rd, 32'(w >= 0 && wr[w]));
    checkOutput("dm_addr", 32'(dm_addr), 32'((w == 1) ? ad[1] : ad[0]));
    checkOutput("dm_wdata", dm_wdata, (w == 1) ? wd[1] : wd[0]);
    checkOutput("rvalid0", rvalid0, 32'(exp_rv0));
    checkOutput("rvalid1", rvalid1, 32'(exp_rv1));
    checkOutput("rdata0", rdata0, exp_rd0);
    checkOutput("rdata1", rdata1, exp_rd1);
    if (tbl_chk) begin
      checkOutput("tbl_gnt0", gnt0, 32'(eg0));
      checkOutput("tbl_gnt1", gnt1, 32'(eg1));
    end
    exp_rv0 = 1'b0;
    exp_rv1 = 1'b0;
    if (w >= 0) begin
      if (wr[w]) ref_mem[ad[w]] = wd[w];
      else if (w == 0) begin exp_rv0 = 1'b1; exp_rd0 = ref_mem[ad[0]]; end
      else begin exp_rv1 = 1'b1; exp_rd1 = ref_mem[ad[1]]; end
      m_last = w;
      m_beats = nb;
      m_owner = (lk[w] && nb < MAXB) ? w : -1;
    end else begin
      m_owner = -1;
      m_beats = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] old_word;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    rst_n = 1'b0;
    applyStimulus(mk(1, 1, 0, 0, 0, 0, 3, 4, 0, 0));
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_gnt0", gnt0, 0);
    checkOutput("rst_gnt1", gnt1, 0);
    checkOutput("rst_dm_wr", dm_wr, 0);
    checkOutput("rst_dm_rd", dm_rd, 0);
    checkOutput("rst_rvalid0", rvalid0, 0);
    checkOutput("rst_rvalid1", rvalid1, 0);
    checkOutput("rst_rdata0", rdata0, 0);
    checkOutput("rst_rdata1", rdata1, 0);
    rst_n = 1'b1;
    modelReset();

    // Contention, capped lock1 burst, lock handover, lock drop, idle re-grant at cap.
    addVec(mk(1, 1, 0, 0, 0, 0, 1, 2, 0, 0), 1, 0);
    addVec(mk(1, 1, 0, 0, 0, 0, 1, 2, 0, 0), 0, 1);
    addVec(mk(1, 1, 0, 0, 0, 0, 1, 2, 0, 0), 1, 0);
    addVec(mk(1, 1, 0, 1, 0, 1, 1, 10, 0, 32'hA0A0_0010), 0, 1);
    addVec(mk(1, 1, 0, 1, 0, 1, 1, 11, 0, 32'hA0A0_0011), 0, 1);
    addVec(mk(1, 1, 0, 0, 0, 1, 1, 10, 0, 0), 0, 1);
    addVec(mk(1, 1, 0, 0, 0, 1, 1, 11, 0, 0), 0, 1);
    addVec(mk(1, 1, 0, 0, 0, 1, 7, 11, 0, 0), 1, 0);
    addVec(mk(1, 1, 0, 0, 0, 1, 7, 12, 0, 0), 0, 1);
    addVec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
    addVec(mk(1, 1, 0, 0, 1, 0, 8, 9, 0, 0), 1, 0);
    addVec(mk(1, 1, 0, 0, 1, 0, 8, 9, 0, 0), 1, 0);
    addVec(mk(0, 1, 0, 0, 1, 0, 8, 9, 0, 0), 0, 1);
    addVec(mk(1, 0, 1, 0, 1, 0, 30, 0, 32'h0000_0030, 0), 1, 0);
    addVec(mk(1, 0, 1, 0, 1, 0, 31, 0, 32'h0000_0031, 0), 1, 0);
    addVec(mk(1, 0, 0, 0, 1, 0, 30, 0, 0, 0), 1, 0);
    addVec(mk(1, 0, 0, 0, 1, 0, 31, 0, 0, 0), 1, 0);
    addVec(mk(1, 0, 0, 0, 1, 0, 30, 0, 0, 0), 1, 0);
    addVec(mk(1, 1, 0, 0, 1, 0, 31, 2, 0, 0), 1, 0);
    addVec(mk(1, 1, 0, 0, 1, 0, 30, 2, 0, 0), 1, 0);
    addVec(mk(1, 1, 0, 0, 1, 0, 31, 2, 0, 0), 1, 0);
    addVec(mk(1, 1, 0, 0, 0, 0, 31, 2, 0, 0), 0, 1);
    foreach (tbl[i]) runCycle(tbl[i].s, 1'b1, tbl[i].exp_g0, tbl[i].exp_g1);

    // Write then read of the same address on consecutive cycles.
    runCycle(mk(1, 0, 1, 0, 0, 0, 5, 0, 32'hDEAD_BEEF, 0), 1'b1, 1, 0);
    runCycle(mk(1, 0, 0, 0, 0, 0, 5, 0, 0, 0), 1'b1, 1, 0);
    checkOutput("wr_rd_rvalid0", rvalid0, 1);
    checkOutput("wr_rd_rdata0", rdata0, 32'hDEAD_BEEF);
    runCycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 0, 0);

    // Reset asserted during the third beat of a locked burst.
    runCycle(mk(1, 0, 1, 0, 1, 0, 20, 0, 32'h5A5A_0001, 0), 1'b1, 1, 0);
    runCycle(mk(1, 1, 0, 0, 1, 0, 20, 3, 0, 0), 1'b1, 1, 0);
    applyStimulus(mk(1, 1, 1, 0, 1, 0, 22, 3, 32'hBAD0_BAD0, 0));
    #2;
    checkOutput("burst3_gnt0", gnt0, 1);
    checkOutput("burst3_rvalid0", rvalid0, 1);
    checkOutput("burst3_rdata0", rdata0, 32'h5A5A_0001);
    old_word = mem[22];
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_gnt0", gnt0, 0);
    checkOutput("midrst_gnt1", gnt1, 0);
    checkOutput("midrst_dm_wr", dm_wr, 0);
    checkOutput("midrst_rvalid0", rvalid0, 0);
    checkOutput("midrst_rdata0", rdata0, 0);
    @(posedge clk);
    #1;
    checkOutput("midrst_nowrite", mem[22], old_word);
    rst_n = 1'b1;
    modelReset();
    runCycle(mk(1, 1, 0, 0, 1, 0, 22, 3, 0, 0), 1'b1, 1, 0);
    runCycle(mk(0, 1, 0, 0, 0, 0, 0, 3, 0, 0), 1'b1, 0, 1);

    // Randomized traffic checked only against the model.
    for (int i = 0; i < 600; i++) begin
      stim_t s;
      s = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
             $urandom, $urandom);
      runCycle(s, 1'b0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter that shares the single-ported 64x32 data memory (`dm`) between the CPU memory stage (port 0) and a DMA/loader port (port 1). It resolves contention round-robin, supports locked bursts capped at MAX_BURST beats, drives the `dm` control and address pins, and returns registered read data with a one-cycle valid pulse to the granted requester.

## Interface
- MAX_BURST, 4, maximum consecutive locked grants to one port (legal 1..15)
- clk  in  1  system clock, all state updates on posedge
- rst_n  in  1  reset; asynchronous, active-low
- req0 / req1  in  1  access request, held until granted
- we0 / we1  in  1  1 = write, 0 = read; valid with req
- lock0 / lock1  in  1  request to keep ownership for the next beat
- addr0 / addr1  in  6  word address
- wdata0 / wdata1  in  32  write data
- gnt0 / gnt1  out  1  combinational grant; transfer happens this cycle
- rvalid0 / rvalid1  out  1  registered read-data valid, one cycle after a read grant
- rdata0 / rdata1  out  32  registered read data
- dm_addr  out  6  to `dm` addr
- dm_wr  out  1  to `dm` wr
- dm_rd  out  1  to `dm` rd
- dm_wdata  out  32  to `dm` wdata
- dm_rdata  in  32  from `dm` rdata

## Operation
- State: fsm in {ARB, LOCK0, LOCK1}; last (winner of most recent grant); cnt[3:0] (beats granted in current lock).
- At most one of gnt0/gnt1 high per cycle; both 0 while rst_n low.
- ARB: if exactly one req, grant it. If both, grant the port != last. If neither, no grant.
- LOCKi: if reqi and cnt < MAX_BURST, grant i regardless of the other port. Otherwise (reqi low or cap reached), arbitrate as ARB this cycle with last = i, so the other port wins on contention.
- Next state after a grant to port i: if locki = 1 and cnt_next < MAX_BURST then LOCKi, else ARB. cnt_next = cnt+1 if continuing a lock, 1 on a fresh grant. No grant -> ARB, cnt = 0. last updates to i on every grant to i.
- Capped port re-acquiring the bus via ARB (other port idle) starts a fresh lock, cnt = 1.
- Mux: dm_addr/dm_wdata follow the granted port; when idle they hold port 0's values. dm_wr = grant & we of granted port.
- dm_rd = 1 only on write grants (dm forwards wdata); on read grants and idle cycles dm_rd = 0, so dm_rdata is the stored word at dm_addr.
- Read grant on port i: at that posedge rdatai <= dm_rdata and rvalidi <= 1; rdata of the other port holds. rvalid pulses exactly one cycle per read grant.
- Writes produce no rvalid; the memory updates at the posedge ending the grant cycle.

## Timing
- Reset values: fsm = ARB, last = 1 (port 0 wins first contention), cnt = 0, rvalid0 = rvalid1 = 0, rdata0 = rdata1 = 0; gnt0/gnt1/dm_wr/dm_rd = 0 while rst_n low.
- Grant latency 0 cycles (combinational from req and registered state); read latency 1 cycle (gnt at cycle N, rvalid/rdata at N+1).
- Back-to-back read grants give rvalid high on consecutive cycles.
- Write at N followed by read of the same address at N+1 returns the new data at N+2.
- Reset asserted mid-burst: fsm returns to ARB, any pending rvalid is cleared immediately, and no write occurs in the reset cycle.
- MAX_BURST = 1: lock is ineffective; pure round-robin.

## Test plan
- Reset: rst_n low with req0 = req1 = 1 -> gnt0 = gnt1 = 0, rvalid = 0, rdata = 0. Release -> first grant goes to port 0.
- Write/read: port 0 writes 0xDEADBEEF to addr 5 at cycle N, reads addr 5 at N+1 -> rvalid0 = 1 and rdata0 = 0xDEADBEEF at N+2; dm_rd = 1 at N and 0 at N+1.
- Contention: both ports continuously request unlocked reads -> grants alternate 0,1,0,1; each rvalid pulses on alternate cycles.
- Locked burst: port 1 holds lock1 = 1 with MAX_BURST = 4 while port 0 requests -> port 1 gets 4 consecutive grants, then port 0 is granted on the 5th cycle.
- Lock drop and idle: port 0 locks, drops req after 2 beats -> port 1 is granted next cycle and fsm = ARB. If port 1 is idle at the cap, port 0 is re-granted with cnt = 1.
- Reset mid-burst: assert rst_n low during the 3rd locked write -> no write occurs and rvalid clears. After release, fsm = ARB and port 0 wins contention.
